// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg
// Shared constants for the multi-channel clock/PWM generator.
//   MODE_TOGGLE / MODE_PWM : encoding of the per-channel mode bit
//   MAX_NUM_CH             : largest supported channel count
package clk_gen_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PWM    = 1'b1;

    localparam int MAX_NUM_CH = 16;

endpackage

// File: rtl/clk_gen_multi_if.sv
// clk_gen_multi_if
// Configuration/control bus of the multi-channel clock generator.
//   ch_en       : per-channel run enable (level)
//   cfg_wr      : per-channel shadow-register write strobe
//   cfg_period  : channel i period P in [i*CNT_W +: CNT_W]
//   cfg_high    : channel i high time H in [i*CNT_W +: CNT_W]
//   cfg_mode    : per-channel mode (0 toggle, 1 PWM)
//   sync_i      : global phase-alignment strobe
//   cfg_pending : per-channel "shadow written, not yet applied"
// master = software/register side, slave = generator.
interface clk_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       cfg_wr;
    logic [NUM_CH*CNT_W-1:0] cfg_period;
    logic [NUM_CH*CNT_W-1:0] cfg_high;
    logic [NUM_CH-1:0]       cfg_mode;
    logic                    sync_i;
    logic [NUM_CH-1:0]       cfg_pending;

    modport master (
        output ch_en, cfg_wr, cfg_period, cfg_high, cfg_mode, sync_i,
        input  cfg_pending
    );

    modport slave (
        input  ch_en, cfg_wr, cfg_period, cfg_high, cfg_mode, sync_i,
        output cfg_pending
    );
endinterface

// File: rtl/clk_gen_ch.sv
// clk_gen_ch
// One generator channel: period counter, shadow and active configuration,
// registered waveform output and end-of-period tick.
//   clk_i, reset_n : clock, asynchronous active-low reset
//   en             : run enable (level)
//   wr             : capture cfg_period/cfg_high/cfg_mode into the shadow
//   sync           : restart at count 0 and apply any pending shadow
//   wave           : generated clock / PWM output (registered)
//   tick           : one-cycle pulse following the last count of a period
//   pending        : shadow holds a value not yet copied to the active set
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter bit RESET_MODE = MODE_TOGGLE
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_mode,
    input  logic             sync,
    output logic             wave,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic             mode_reg, mode_next;
    logic [CNT_W-1:0] sh_period_reg, sh_period_next;
    logic [CNT_W-1:0] sh_high_reg, sh_high_next;
    logic             sh_mode_reg, sh_mode_next;
    logic             pending_reg, pending_next;
    logic             wave_reg, wave_next;
    logic             tick_reg, tick_next;

    logic at_end;
    logic apply;

    always_comb begin
        at_end = (cnt_reg == period_reg);
        // Only copy when something was written, so the reset mode survives
        // until software actually programs the channel.
        apply  = pending_reg & (~en | sync | at_end);

        cnt_next       = cnt_reg;
        period_next    = period_reg;
        high_next      = high_reg;
        mode_next      = mode_reg;
        sh_period_next = sh_period_reg;
        sh_high_next   = sh_high_reg;
        sh_mode_next   = sh_mode_reg;
        pending_next   = pending_reg;
        wave_next      = wave_reg;
        tick_next      = 1'b0;

        if (apply) begin
            period_next  = sh_period_reg;
            high_next    = sh_high_reg;
            mode_next    = sh_mode_reg;
            pending_next = 1'b0;
        end

        // A write coinciding with an apply lands in the shadow and stays
        // pending for the following boundary; the apply above uses the old shadow.
        if (wr) begin
            sh_period_next = cfg_period;
            sh_high_next   = cfg_high;
            sh_mode_next   = cfg_mode;
            pending_next   = 1'b1;
        end

        if (!en || sync || at_end) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        if (!en) begin
            wave_next = 1'b0;
        end else if (mode_reg == MODE_PWM) begin
            wave_next = (cnt_reg < high_reg);
        end else if (sync) begin
            wave_next = 1'b0;
        end else if (at_end) begin
            wave_next = ~wave_reg;
        end

        // sync suppresses the wrap, so no tick for a cut-short period.
        tick_next = en & at_end & ~sync;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg       <= '0;
            period_reg    <= '0;
            high_reg      <= '0;
            mode_reg      <= RESET_MODE;
            sh_period_reg <= '0;
            sh_high_reg   <= '0;
            sh_mode_reg   <= 1'b0;
            pending_reg   <= 1'b0;
            wave_reg      <= 1'b0;
            tick_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            period_reg    <= period_next;
            high_reg      <= high_next;
            mode_reg      <= mode_next;
            sh_period_reg <= sh_period_next;
            sh_high_reg   <= sh_high_next;
            sh_mode_reg   <= sh_mode_next;
            pending_reg   <= pending_next;
            wave_reg      <= wave_next;
            tick_reg      <= tick_next;
        end
    end

    assign wave    = wave_reg;
    assign tick    = tick_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/clk_gen_multi.sv
// clk_gen_multi
// Multi-channel clock/PWM generator with glitch-free shadowed configuration
// and a global phase-alignment strobe.
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : configuration/control bus (slave side)
//   clk_o   : generated clocks / PWM outputs, one per channel
//   tick_o  : per-channel end-of-period pulse
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter bit RESET_MODE = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_n,
    clk_gen_multi_if.slave    bus,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
        $error("clk_gen_multi: NUM_CH out of range");
    end

    logic [NUM_CH-1:0] pending_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clk_gen_ch #(
                .CNT_W      (CNT_W),
                .RESET_MODE (RESET_MODE)
            ) u_ch (
                .clk_i      (clk_i),
                .reset_n    (reset_n),
                .en         (bus.ch_en[gi]),
                .wr         (bus.cfg_wr[gi]),
                .cfg_period (bus.cfg_period[gi*CNT_W +: CNT_W]),
                .cfg_high   (bus.cfg_high[gi*CNT_W +: CNT_W]),
                .cfg_mode   (bus.cfg_mode[gi]),
                .sync       (bus.sync_i),
                .wave       (clk_o[gi]),
                .tick       (tick_o[gi]),
                .pending    (pending_w[gi])
            );
        end
    endgenerate

    assign bus.cfg_pending = pending_w;

endmodule

// File: tb/tb_clk_gen_multi.sv
module tb_clk_gen_multi;
    import clk_gen_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic clk;
    logic reset_n;
    logic [NUM_CH-1:0] clk_o;
    logic [NUM_CH-1:0] tick_o;

    int checks = 0;
    int errors = 0;

    clk_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_gen_multi #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .RESET_MODE (1'b0)
    ) dut (
        .clk_i   (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .clk_o   (clk_o),
        .tick_o  (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.ch_en      = '0;
        bus.cfg_wr     = '0;
        bus.cfg_period = '0;
        bus.cfg_high   = '0;
        bus.cfg_mode   = '0;
        bus.sync_i     = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic set_fields(input int ch, input int p, input int h, input logic m);
        bus.cfg_period[ch*CNT_W +: CNT_W] = p;
        bus.cfg_high[ch*CNT_W +: CNT_W]   = h;
        bus.cfg_mode[ch]                  = m;
    endtask

    // Write a channel's shadow while disabled; the idle cycle applies it.
    task automatic cfg_load(input int ch, input int p, input int h, input logic m);
        set_fields(ch, p, h, m);
        bus.cfg_wr[ch] = 1'b1;
        step();
        bus.cfg_wr[ch] = 1'b0;
        step();
    endtask

    // Compare one channel against hand-written clk/tick patterns, first edge at MSB.
    task automatic run_pattern(input string name, input int ch, input int n,
                               input logic [15:0] exp_clk, input logic [15:0] exp_tick);
        for (int e = 1; e <= n; e++) begin
            step();
            checks++;
            if (clk_o[ch] !== exp_clk[n-e]) begin
                errors++;
                $display("FAIL %s clk_o[%0d] edge %0d: got %b expected %b", name, ch, e, clk_o[ch], exp_clk[n-e]);
            end
            checks++;
            if (tick_o[ch] !== exp_tick[n-e]) begin
                errors++;
                $display("FAIL %s tick_o[%0d] edge %0d: got %b expected %b", name, ch, e, tick_o[ch], exp_tick[n-e]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.ch_en = '1;
        bus.cfg_wr = '0;
        bus.sync_i = 1'b0;
        #3;
        checks++;
        if (clk_o !== 4'b0000 || tick_o !== 4'b0000 || bus.cfg_pending !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: clk_o=%b tick_o=%b pending=%b expected 0/0/0", clk_o, tick_o, bus.cfg_pending);
        end
        do_reset();
        checks++;
        if (clk_o !== 4'b0000 || tick_o !== 4'b0000 || bus.cfg_pending !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: clk_o=%b tick_o=%b pending=%b expected 0/0/0", clk_o, tick_o, bus.cfg_pending);
        end
        $display("test_reset done");
    endtask

    task automatic test_pwm();
        do_reset();
        set_fields(0, 3, 1, MODE_PWM);
        bus.cfg_wr[0] = 1'b1;
        step();
        bus.cfg_wr[0] = 1'b0;
        checks++;
        if (bus.cfg_pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL pwm_pending_set: got %b expected 1", bus.cfg_pending[0]);
        end
        step();
        checks++;
        if (bus.cfg_pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL pwm_pending_apply: got %b expected 0", bus.cfg_pending[0]);
        end
        bus.ch_en[0] = 1'b1;
        run_pattern("pwm_p3_h1", 0, 8, 16'b10001000, 16'b00010001);
        $display("test_pwm done");
    endtask

    task automatic test_toggle();
        do_reset();
        cfg_load(1, 0, 0, MODE_TOGGLE);
        bus.ch_en[1] = 1'b1;
        run_pattern("toggle_div2", 1, 4, 16'b1010, 16'b1111);
        // Reprogram P=4 mid-stream; old period ends, then 5 low / 5 high.
        set_fields(1, 4, 0, MODE_TOGGLE);
        bus.cfg_wr[1] = 1'b1;
        step();
        bus.cfg_wr[1] = 1'b0;
        checks++;
        if (clk_o[1] !== 1'b1 || tick_o[1] !== 1'b1 || bus.cfg_pending[1] !== 1'b1) begin
            errors++;
            $display("FAIL toggle_write: clk=%b tick=%b pending=%b expected 1/1/1", clk_o[1], tick_o[1], bus.cfg_pending[1]);
        end
        run_pattern("toggle_p4", 1, 11, 16'b00000111110, 16'b10000100001);
        checks++;
        if (bus.cfg_pending[1] !== 1'b0) begin
            errors++;
            $display("FAIL toggle_pending_clear: got %b expected 0", bus.cfg_pending[1]);
        end
        $display("test_toggle done");
    endtask

    task automatic test_shadow();
        logic [15:0] exp_clk;
        logic [15:0] exp_tick;
        logic [15:0] exp_pend;
        exp_clk  = 16'b1111100000110001;
        exp_tick = 16'b0000000001000010;
        exp_pend = 16'b0000011110000000;
        do_reset();
        cfg_load(0, 9, 5, MODE_PWM);
        set_fields(0, 4, 2, MODE_PWM);
        bus.ch_en[0] = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            bus.cfg_wr[0] = (e == 6);
            step();
            checks++;
            if (clk_o[0] !== exp_clk[16-e] || tick_o[0] !== exp_tick[16-e] || bus.cfg_pending[0] !== exp_pend[16-e]) begin
                errors++;
                $display("FAIL shadow edge %0d: clk=%b tick=%b pending=%b expected %b/%b/%b", e,
                         clk_o[0], tick_o[0], bus.cfg_pending[0], exp_clk[16-e], exp_tick[16-e], exp_pend[16-e]);
            end
        end
        bus.cfg_wr[0] = 1'b0;
        $display("test_shadow done");
    endtask

    task automatic test_pwm_edges();
        do_reset();
        cfg_load(0, 2, 0, MODE_PWM);
        bus.ch_en[0] = 1'b1;
        run_pattern("pwm_h0", 0, 6, 16'b000000, 16'b001001);
        do_reset();
        cfg_load(0, 2, 3, MODE_PWM);
        bus.ch_en[0] = 1'b1;
        run_pattern("pwm_h_p1", 0, 6, 16'b111111, 16'b001001);
        $display("test_pwm_edges done");
    endtask

    task automatic test_sync();
        do_reset();
        cfg_load(0, 2, 0, MODE_TOGGLE);
        cfg_load(2, 2, 0, MODE_TOGGLE);
        bus.ch_en[0] = 1'b1;
        step();
        step();
        step();
        bus.ch_en[2] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.sync_i = 1'b1;
        step();
        bus.sync_i = 1'b0;
        checks++;
        if (clk_o[0] !== 1'b0 || clk_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL sync_low: clk_o[0]=%b clk_o[2]=%b expected 0/0", clk_o[0], clk_o[2]);
        end
        for (int e = 1; e <= 6; e++) begin
            logic [5:0] ec;
            logic [5:0] et;
            ec = 6'b001110;
            et = 6'b001001;
            step();
            checks++;
            if (clk_o[0] !== ec[6-e] || clk_o[2] !== ec[6-e] || tick_o[0] !== et[6-e] || tick_o[2] !== et[6-e]) begin
                errors++;
                $display("FAIL sync_phase edge %0d: clk0=%b clk2=%b tick0=%b tick2=%b expected clk %b tick %b",
                         e, clk_o[0], clk_o[2], tick_o[0], tick_o[2], ec[6-e], et[6-e]);
            end
        end
        $display("test_sync done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_load(0, 9, 5, MODE_PWM);
        bus.ch_en[0] = 1'b1;
        step();
        step();
        step();
        set_fields(0, 4, 2, MODE_PWM);
        bus.cfg_wr[0] = 1'b1;
        step();
        bus.cfg_wr[0] = 1'b0;
        checks++;
        if (bus.cfg_pending[0] !== 1'b1 || clk_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: pending=%b clk=%b expected 1/1", bus.cfg_pending[0], clk_o[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (clk_o !== 4'b0000 || tick_o !== 4'b0000 || bus.cfg_pending !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: clk_o=%b tick_o=%b pending=%b expected 0/0/0", clk_o, tick_o, bus.cfg_pending);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Back to P=0, toggle mode: divide-by-2 with a tick every cycle.
        run_pattern("reset_mode_run", 0, 4, 16'b1010, 16'b1111);
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_toggle();
        test_shadow();
        test_pwm_edges();
        test_sync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
